// File: rtl/mem_lsu_if.sv
// Data-memory request/response bus between the MEM stage and the AXI master wrapper.
// Signal names keep the LSU-side direction suffix so both ends read the same.
interface mem_lsu_if #(
   parameter int XLEN          = 32,
   parameter int AXI_DATA_BITS = 32
);
   logic                         req_valid_o;
   logic                         req_ready_i;
   logic                         req_we_o;
   logic [XLEN-1:0]              req_addr_o;
   logic [AXI_DATA_BITS/8-1:0]   req_wstrb_o;
   logic [AXI_DATA_BITS-1:0]     req_wdata_o;
   logic                         resp_valid_i;
   logic [AXI_DATA_BITS-1:0]     resp_rdata_i;
   logic                         resp_err_i;

   modport master (
      output req_valid_o, req_we_o, req_addr_o, req_wstrb_o, req_wdata_o,
      input  req_ready_i, resp_valid_i, resp_rdata_i, resp_err_i
   );

   modport slave (
      input  req_valid_o, req_we_o, req_addr_o, req_wstrb_o, req_wdata_o,
      output req_ready_i, resp_valid_i, resp_rdata_i, resp_err_i
   );
endinterface

// File: rtl/mem_lsu_stage.sv
// RV32I MEM stage: turns EX/MEM loads/stores into a lane-aligned valid/ready memory
// transaction, stalls until the response, extends load data, flags misalign/bus errors.
module mem_lsu_stage #(
   parameter int XLEN           = 32,
   parameter int AXI_DATA_BITS  = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit MISALIGN_CHECK = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [XLEN-1:0]     mem_addr_i,
   input  logic                mem_ren_i,
   input  logic                mem_wen_i,
   input  logic [2:0]          mem_funct3_i,
   input  logic [XLEN-1:0]     mem_wdata_i,
   mem_lsu_if.master           bus,
   output logic [XLEN-1:0]     mem_rdata_o,
   output logic                stall_o,
   output logic                misalign_o,
   output logic                bus_err_o
);
   localparam int SW = AXI_DATA_BITS / 8;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                   state_q, state_d;
   logic                     we_q;
   logic [XLEN-1:0]          addr_q;
   logic [SW-1:0]            strb_q;
   logic [AXI_DATA_BITS-1:0] wdata_q;
   logic [2:0]               f3_q;
   logic [1:0]               off_q;
   logic [XLEN-1:0]          rdata_q;
   logic                     bus_err_q;
   logic [CW-1:0]            cnt_q;

   // Unsupported funct3 encodings (011/110/111) fall into the word case.
   logic is_b, is_h, is_w, access, misalign, timeout;
   logic [1:0] off;
   logic [SW-1:0] strb;
   logic [AXI_DATA_BITS-1:0] wdata_rep, rsh;
   logic [XLEN-1:0] ext;

   assign is_b     = (mem_funct3_i[1:0] == 2'b00);
   assign is_h     = (mem_funct3_i[1:0] == 2'b01);
   assign is_w     = !is_b && !is_h;
   assign access   = mem_ren_i || mem_wen_i;
   assign misalign = MISALIGN_CHECK &&
                     ((is_h && mem_addr_i[0]) || (is_w && (mem_addr_i[1:0] != 2'b00)));
   // Forcing the offset aligned also covers the MISALIGN_CHECK=0 case.
   assign off      = is_w ? 2'b00 : (is_h ? {mem_addr_i[1], 1'b0} : mem_addr_i[1:0]);
   assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

   always_comb begin
      strb      = '0;
      wdata_rep = mem_wdata_i;
      if (is_b) begin
         wdata_rep = {4{mem_wdata_i[7:0]}};
         if (mem_wen_i) strb = SW'(4'b0001 << off);
      end else if (is_h) begin
         wdata_rep = {2{mem_wdata_i[15:0]}};
         if (mem_wen_i) strb = SW'(4'b0011 << off);
      end else if (mem_wen_i) begin
         strb = '1;
      end
   end

   assign rsh = bus.resp_rdata_i >> {off_q, 3'b000};

   always_comb begin
      case (f3_q[1:0])
         2'b00:   ext = f3_q[2] ? {{(XLEN-8){1'b0}}, rsh[7:0]}
                                : {{(XLEN-8){rsh[7]}}, rsh[7:0]};
         2'b01:   ext = f3_q[2] ? {{(XLEN-16){1'b0}}, rsh[15:0]}
                                : {{(XLEN-16){rsh[15]}}, rsh[15:0]};
         default: ext = rsh;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (access && !misalign) state_d = REQ;
         REQ:  if (bus.req_ready_i)     state_d = WAIT;
         WAIT: if (bus.resp_valid_i || timeout) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_valid_o = (state_q == REQ);
      stall_o         = (state_q == REQ) || (state_q == WAIT) ||
                        ((state_q == IDLE) && access && !misalign);
      misalign_o      = (state_q == IDLE) && access && misalign;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q      <= 1'b0;
         addr_q    <= '0;
         strb_q    <= '0;
         wdata_q   <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         bus_err_q <= 1'b0;
         case (state_q)
            IDLE: if (access) begin
               if (misalign) begin
                  rdata_q <= '0;
               end else begin
                  we_q    <= mem_wen_i;
                  addr_q  <= {mem_addr_i[XLEN-1:2], 2'b00};
                  strb_q  <= strb;
                  wdata_q <= wdata_rep;
                  f3_q    <= mem_funct3_i;
                  off_q   <= off;
               end
            end
            REQ: if (bus.req_ready_i) cnt_q <= '0;
            WAIT: begin
               cnt_q <= cnt_q + CW'(1);
               if (bus.resp_valid_i) begin
                  if (!we_q) rdata_q <= ext;
                  bus_err_q <= bus.resp_err_i;
               end else if (timeout) begin
                  bus_err_q <= 1'b1;
                  rdata_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_we_o    = we_q;
   assign bus.req_addr_o  = addr_q;
   assign bus.req_wstrb_o = strb_q;
   assign bus.req_wdata_o = wdata_q;
   assign mem_rdata_o     = rdata_q;
   assign bus_err_o       = bus_err_q;
endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: stimulus queues expected requests/results,
// a negedge monitor compares whatever the DUT presents.
module tb_mem_lsu_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
   logic        mem_ren_i, mem_wen_i;
   logic [2:0]  mem_funct3_i;
   logic        stall_o, misalign_o, bus_err_o;

   always #5 clk = ~clk;

   mem_lsu_if #(.XLEN(32), .AXI_DATA_BITS(32)) bus ();

   mem_lsu_stage #(.XLEN(32), .AXI_DATA_BITS(32), .TIMEOUT_CYCLES(4), .MISALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst(rst),
      .mem_addr_i(mem_addr_i), .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
      .mem_funct3_i(mem_funct3_i), .mem_wdata_i(mem_wdata_i),
      .bus(bus),
      .mem_rdata_o(mem_rdata_o), .stall_o(stall_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   typedef struct {logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;} req_t;
   typedef struct {logic [31:0] rdata; logic err; int stalls;} res_t;

   req_t req_q[$];
   res_t res_q[$];
   int   mis_q[$];
   int   checks = 0;
   int   fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      fails++;
      $display("FAIL %s: event not expected at this point", name);
   endtask

   // Monitor
   int   stall_cnt = 0;
   bit   zero_chk  = 1'b0;
   req_t mr;
   res_t ms;

   always @(negedge clk) begin
      if (rst) begin
         stall_cnt = 0;
         zero_chk  = 1'b0;
      end else begin
         if (zero_chk) begin
            chk("misalign_rdata", mem_rdata_o, 32'h0);
            zero_chk = 1'b0;
         end
         if (bus.req_valid_o) begin
            if (req_q.size() == 0) flag("unexpected_req");
            else begin
               mr = req_q[0];
               chk("req_we",    {31'h0, bus.req_we_o}, {31'h0, mr.we});
               chk("req_addr",  bus.req_addr_o, mr.addr);
               chk("req_wstrb", {28'h0, bus.req_wstrb_o}, {28'h0, mr.strb});
               chk("req_wdata", bus.req_wdata_o, mr.wdata);
               if (bus.req_ready_i) void'(req_q.pop_front());
            end
         end
         if (misalign_o) begin
            if (mis_q.size() == 0) flag("unexpected_misalign");
            else begin
               void'(mis_q.pop_front());
               chk("misalign_stall", {31'h0, stall_o}, 32'h0);
               chk("misalign_noreq", {31'h0, bus.req_valid_o}, 32'h0);
               zero_chk = 1'b1;
            end
         end
         if (stall_o) stall_cnt++;
         else if (stall_cnt > 0) begin
            if (res_q.size() == 0) flag("unexpected_completion");
            else begin
               ms = res_q.pop_front();
               chk("rdata",   mem_rdata_o, ms.rdata);
               chk("bus_err", {31'h0, bus_err_o}, {31'h0, ms.err});
               chk("stalls",  stall_cnt, ms.stalls);
            end
            stall_cnt = 0;
         end else if (bus_err_o) begin
            chk("spurious_bus_err", {31'h0, bus_err_o}, 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access with a scripted memory: ready after rdy cycles, response after rsp
   // WAIT cycles (rsp < 0: never respond).
   task automatic acc(input logic w, input logic [2:0] f, input logic [31:0] a, wd,
                      input int rdy, input int rsp, input logic [31:0] rd, input logic er,
                      input logic [3:0] xs, input logic [31:0] xw,
                      input logic [31:0] xr, input logic xe, input int xst);
      int n;
      req_q.push_back('{w, a & 32'hFFFF_FFFC, xs, xw});
      res_q.push_back('{xr, xe, xst});
      mem_ren_i = !w; mem_wen_i = w; mem_funct3_i = f; mem_addr_i = a; mem_wdata_i = wd;
      n = 0;
      while (!bus.req_valid_o && n < 8) begin tick(); n++; end
      if (!bus.req_valid_o) flag("req_valid_timeout");
      repeat (rdy) tick();
      bus.req_ready_i = 1'b1;
      tick();
      bus.req_ready_i = 1'b0;
      if (rsp >= 0) begin
         repeat (rsp) tick();
         bus.resp_valid_i = 1'b1; bus.resp_rdata_i = rd; bus.resp_err_i = er;
         tick();
         bus.resp_valid_i = 1'b0; bus.resp_err_i = 1'b0;
      end
      n = 0;
      while (stall_o && n < 20) begin tick(); n++; end
      if (stall_o) flag("done_timeout");
      tick();
      mem_ren_i = 1'b0; mem_wen_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mem_addr_i = '0; mem_wdata_i = '0; mem_ren_i = 1'b0; mem_wen_i = 1'b0; mem_funct3_i = '0;
      bus.req_ready_i = 1'b0; bus.resp_valid_i = 1'b0; bus.resp_rdata_i = '0; bus.resp_err_i = 1'b0;
      repeat (2) tick();
      chk("rst_req_valid", {31'h0, bus.req_valid_o}, 32'h0);
      chk("rst_req_we",    {31'h0, bus.req_we_o}, 32'h0);
      chk("rst_req_addr",  bus.req_addr_o, 32'h0);
      chk("rst_req_wstrb", {28'h0, bus.req_wstrb_o}, 32'h0);
      chk("rst_req_wdata", bus.req_wdata_o, 32'h0);
      chk("rst_rdata",     mem_rdata_o, 32'h0);
      chk("rst_stall",     {31'h0, stall_o}, 32'h0);
      chk("rst_misalign",  {31'h0, misalign_o}, 32'h0);
      chk("rst_bus_err",   {31'h0, bus_err_o}, 32'h0);
      rst = 1'b0;
      tick();

      //  w     f3      addr          wdata      rdy rsp rdata          err strb     exp wdata      exp rdata     err stalls
      acc(1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 0, 32'h80FF_1234, 0, 4'b0000, 32'h0,         32'hFFFF_FF80, 0, 3); // LB
      acc(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 32'h0,        0, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80, 0, 3); // SH
      acc(1'b0, 3'b101, 32'h0000_0102, 32'h0,        0, 0, 32'h9876_0000, 0, 4'b0000, 32'h0,         32'h0000_9876, 0, 3); // LHU

      mis_q.push_back(1);                     // LW 0x101 misaligned
      mem_ren_i = 1'b1; mem_funct3_i = 3'b010; mem_addr_i = 32'h0000_0101;
      tick();
      mem_ren_i = 1'b0;
      tick();

      acc(1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 5, 0, 32'h0,        0, 4'b0010, 32'h5A5A_5A5A, 32'h0,         0, 8); // SB, ready late
      acc(1'b0, 3'b001, 32'h0000_0206, 32'h0,        0, 2, 32'h8001_0000, 0, 4'b0000, 32'h0,         32'hFFFF_8001, 0, 5); // LH
      acc(1'b0, 3'b010, 32'h0000_0300, 32'h0,        0, 0, 32'h1234_5678, 1, 4'b0000, 32'h0,         32'h1234_5678, 1, 3); // LW bus err
      acc(1'b0, 3'b100, 32'h0000_0304, 32'h0,        0, -1, 32'h0,        0, 4'b0000, 32'h0,         32'h0,         1, 6); // LBU timeout

      bus.resp_valid_i = 1'b1; bus.resp_rdata_i = 32'hFFFF_FFFF; bus.resp_err_i = 1'b1;
      tick();
      bus.resp_valid_i = 1'b0; bus.resp_err_i = 1'b0;
      chk("late_resp_bus_err", {31'h0, bus_err_o}, 32'h0);
      chk("late_resp_rdata",   mem_rdata_o, 32'h0);
      chk("late_resp_stall",   {31'h0, stall_o}, 32'h0);

      acc(1'b1, 3'b011, 32'h0000_0040, 32'h1122_3344, 0, 0, 32'h0,        0, 4'b1111, 32'h1122_3344, 32'h0,         0, 3); // f3=011 as SW
      acc(1'b0, 3'b010, 32'h0000_0008, 32'h0,        0, 0, 32'h55AA_55AA, 0, 4'b0000, 32'h0,         32'h55AA_55AA, 0, 3); // LW

      // Reset while waiting for the response.
      req_q.push_back('{1'b0, 32'h0000_0010, 4'b0000, 32'h0});
      mem_ren_i = 1'b1; mem_funct3_i = 3'b010; mem_addr_i = 32'h0000_0010; mem_wdata_i = '0;
      tick();
      bus.req_ready_i = 1'b1;
      tick();
      bus.req_ready_i = 1'b0;
      mem_ren_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_req_valid", {31'h0, bus.req_valid_o}, 32'h0);
      chk("midrst_stall",     {31'h0, stall_o}, 32'h0);
      chk("midrst_rdata",     mem_rdata_o, 32'h0);
      tick();
      rst = 1'b0;
      bus.resp_valid_i = 1'b1; bus.resp_rdata_i = 32'hDEAD_BEEF; bus.resp_err_i = 1'b1;
      tick();
      bus.resp_valid_i = 1'b0; bus.resp_err_i = 1'b0;
      chk("dropped_resp_rdata",   mem_rdata_o, 32'h0);
      chk("dropped_resp_bus_err", {31'h0, bus_err_o}, 32'h0);

      acc(1'b0, 3'b010, 32'h0000_0000, 32'h0,        0, 0, 32'hCAFE_BABE, 0, 4'b0000, 32'h0,         32'hCAFE_BABE, 0, 3); // LW after reset

      repeat (3) tick();
      chk("req_q_left", req_q.size(), 32'h0);
      chk("res_q_left", res_q.size(), 32'h0);
      chk("mis_q_left", mis_q.size(), 32'h0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
Next-generation MEM stage for the 5-stage RV32I core, replacing the pure pass-through. It turns the EX/MEM load/store request into a byte-lane-aligned, valid/ready data-memory transaction and stalls the pipeline until the response returns. It sign- or zero-extends load data, detects misaligned accesses, and flags bus errors and timeouts. It sits between the EX/MEM and MEM/WB pipeline registers, and its memory side connects to the AXI master wrapper.

Parameters:
XLEN, 32, datapath and address width
AXI_DATA_BITS, 32, memory data width; strobe width is AXI_DATA_BITS/8 (must equal XLEN in this generation)
TIMEOUT_CYCLES, 255, maximum cycles in WAIT before a timeout error; 0 disables the timeout
MISALIGN_CHECK, 1, 1 = misaligned accesses fault without a bus access; 0 = address low bits ignored (forced aligned)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
mem_addr_i  in  XLEN  byte address from EX
mem_ren_i  in  1  load request
mem_wen_i  in  1  store request; ren and wen are never both 1
mem_funct3_i  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_wdata_i  in  XLEN  unshifted store data (rs2)
req_valid_o  out  1  memory request valid
req_ready_i  in  1  memory accepts request
req_we_o  out  1  1 = write
req_addr_o  out  XLEN  word-aligned address (addr[1:0]=0)
req_wstrb_o  out  AXI_DATA_BITS/8  byte-lane strobe
req_wdata_o  out  AXI_DATA_BITS  lane-shifted store data
resp_valid_i  in  1  response valid (read data or write ack)
resp_rdata_i  in  AXI_DATA_BITS  read word
resp_err_i  in  1  bus error with the response
mem_rdata_o  out  XLEN  extended load result toward WB
stall_o  out  1  freeze IF..EX/MEM registers
misalign_o  out  1  one-cycle misaligned-access pulse
bus_err_o  out  1  one-cycle bus-error/timeout pulse

Behaviour:
- Reset values: state IDLE; req_valid_o 0, req_we_o 0, req_addr_o 0, req_wstrb_o 0, req_wdata_o 0, mem_rdata_o 0, stall_o 0, misalign_o 0, bus_err_o 0, timeout counter 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - No access: stall_o 0; mem_rdata_o holds its value.
  - Aligned access (ren|wen): stall_o=1 combinationally in the same cycle. Latch we, word address, strobe, shifted wdata, funct3 and addr[1:0]. Go to REQ.
  - Misaligned access with MISALIGN_CHECK=1 (H with addr[0]=1; W with addr[1:0]!=0): no request and no stall. misalign_o=1 for that cycle; mem_rdata_o<=0 next edge; stay in IDLE.
- REQ: req_valid_o=1 with stable payload until req_ready_i. On handshake go to WAIT and clear the counter.
- WAIT:
  - req_valid_o=0; counter increments every cycle.
  - On resp_valid_i:
    - Loads: mem_rdata_o<=extend(resp_rdata_i >> 8*off).
    - Stores: mem_rdata_o unchanged.
    - bus_err_o<=resp_err_i.
    - Go to DONE.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no response: bus_err_o=1 pulse, mem_rdata_o<=0, go to DONE.
  - A late response after a timeout is ignored.
- DONE: stall_o=0 for one cycle so the pipeline advances; ignore the inputs (still the same instruction); go to IDLE unconditionally.
- stall_o=1 in REQ and WAIT, and in IDLE when an aligned access is present.
- Minimum latency with ready and response each one cycle: 3 stall cycles, result valid in the DONE cycle.
- Strobes:
  - B: 1<<off
  - H: 0011<<off (off in {0,2})
  - W: 1111
  - Loads: 0000
- wdata replication: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W unchanged.
- Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Response timing: resp_valid_i is honoured only in WAIT. The memory must not respond in the accepting cycle.
- Unsupported funct3 (011, 110, 111): treated as W.
- Reset mid-transaction: asynchronous return to IDLE, all outputs to reset values; an outstanding response is dropped.

Test Plan:
- LB addr 0x103, resp_rdata 0x80FF_1234, ready and response each 1 cycle -> req_addr 0x100, wstrb 0000; mem_rdata_o 0xFFFF_FF80; stall_o high exactly 3 cycles.
- SH addr 0x202, wdata 0x0000_ABCD -> req_we 1, req_addr 0x200, wstrb 1100, wdata 0xABCD_ABCD; mem_rdata_o unchanged.
- LHU addr 0x102, rdata 0x9876_0000 -> 0x0000_9876. LW addr 0x101 -> misalign_o pulse, no req_valid_o, stall_o 0, mem_rdata_o 0.
- req_ready_i held low 5 cycles -> req_valid_o and payload stable throughout, stall_o held; completes after ready.
- TIMEOUT_CYCLES=4, no response -> bus_err_o pulse after 4 WAIT cycles, then DONE and IDLE; a later resp_valid_i is ignored.
- rst asserted during WAIT -> req_valid_o, stall_o and mem_rdata_o go to 0 immediately; the next LW 0x0 completes normally.
